uart_prog_loader: RTL and testbench
===================================

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per UART bit (100 MHz / 115200 baud).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the asynchronous active-high reset.
REQ-004 The block SHALL have port rx_i, input, 1, the UART serial line (8N1, idle high, LSB first), asynchronous to clk.
REQ-005 The block SHALL have port upg_wen_o, output, 1, the instruction-memory write strobe, one cycle per completed word.
REQ-006 The block SHALL have port upg_adr_o, output, 14, the word address for the write.
REQ-007 The block SHALL have port upg_dat_o, output, 32, the instruction word for the write.
REQ-008 The block SHALL have port upg_done_o, output, 1, indicating the image is fully loaded (sticky).
REQ-009 The block SHALL have port err_o, output, 1, a sticky flag for framing or length errors.

Function
REQ-010 rx_i SHALL pass through a 2-flop synchronizer before any use.
REQ-011 RX FSM states SHALL be IDLE, START, DATA, STOP.
- IDLE -> START on synchronized rx = 0.
REQ-012 In START, after CLKS_PER_BIT/2 cycles the line SHALL be resampled.
- Low: enter DATA.
- High: treat as a glitch and return to IDLE with no byte and no error.
REQ-013 In DATA, 8 bits SHALL be sampled every CLKS_PER_BIT cycles, LSB first; then one more sample SHALL be taken in STOP.
REQ-014 Stop sample = 1 SHALL produce an internal byte-valid pulse of exactly one cycle.
- Stop sample = 0 SHALL discard the byte, set err_o, and return to IDLE.
REQ-015 Loader FSM states SHALL be LEN, DATA, DONE; LEN is entered at reset.
REQ-016 In LEN, 4 bytes SHALL be collected little-endian into a 32-bit word count N.
REQ-017 When the 4th LEN byte arrives, the loader SHALL branch on N:
- N = 0: go to DONE.
- 1 <= N <= 16384: go to DATA.
- N > 16384: set err_o, clear the byte counter, remain in LEN awaiting a new header.
REQ-018 In DATA, bytes SHALL be assembled little-endian (first byte -> bits 7:0) into a 32-bit word.
REQ-019 On the cycle after the 4th byte of a word, the loader SHALL drive:
- upg_wen_o = 1 for exactly one cycle;
- upg_dat_o = the assembled word;
- upg_adr_o = the word index, starting at 0 and incrementing by 1 per word.
REQ-020 upg_adr_o and upg_dat_o SHALL hold their last values between strobes.
REQ-021 After the N-th word strobe, the FSM SHALL enter DONE, and upg_done_o SHALL rise in the same cycle as that strobe.
REQ-022 In DONE, upg_done_o SHALL stay 1 and further bytes SHALL be ignored (no strobes) until rst.
REQ-023 A framing error SHALL NOT consume a byte slot; the partially assembled word or count SHALL be retained.
REQ-024 The address counter SHALL be 14 bits and SHALL never wrap, since N <= 16384 is enforced.
REQ-025 A byte-valid pulse and a word strobe SHALL never be lost when they occur in the same cycle; RX continues independently of loader output.

Reset
REQ-026 While rst = 1, the block SHALL force:
- RX FSM to IDLE;
- loader FSM to LEN;
- all counters and shift registers to 0;
- upg_wen_o = 0, upg_adr_o = 0, upg_dat_o = 0, upg_done_o = 0, err_o = 0.
REQ-027 rst asserted mid-byte or mid-image SHALL abandon all progress.
- After release, the next byte SHALL be treated as LEN byte 0.
- The line SHALL be accepted only after a fresh start bit.
REQ-028 On rst release, no output SHALL change until a valid byte completes.

Verification
REQ-029 Header 01 00 00 00, then bytes 13 05 00 00 -> one strobe: adr = 0, dat = 0x00000513; upg_done_o = 1 in the same cycle; err_o = 0.
REQ-030 N = 3 with words 0x11111111, 0x22222222, 0x33333333 -> strobes at adr 0, 1, 2 with matching data; done rises with the third strobe.
REQ-031 Framing error injected on the 2nd data byte, then resent -> err_o = 1 and the word is still assembled correctly with no extra strobe.
REQ-032 Header 01 40 00 00 (N = 16385) -> err_o = 1, no strobe; a following header 00 00 00 00 -> upg_done_o = 1.
REQ-033 rst pulsed after 2 of 4 bytes of word 1 (N = 2) -> all outputs 0; full resend of header and image completes normally from adr 0.
REQ-034 A 0.3-bit low glitch on rx_i while idle -> no byte, err_o stays 0; subsequent bytes decode correctly.

Source files
------------

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART 8N1 receiver feeding a length-prefixed instruction-memory loader
// Image format: 4-byte little-endian word count N, then N little-endian 32-bit words.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_i,
  output logic        upg_wen_o,
  output logic [13:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]   MAX_WORDS = 32'd16384;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {LD_LEN, LD_DATA, LD_DONE} ld_state_t;

  // Synchronizer resets to the idle-high level so reset release never looks like a start bit.
  logic rx_meta, rx_sync;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
    end
  end

  rx_state_t     rx_state, rx_state_nx;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_sh;
  logic          byte_valid, frame_err;
  logic          bit_tick, half_tick;

  assign bit_tick  = (clk_cnt == BIT_LAST);
  assign half_tick = (clk_cnt == HALF_LAST);

  always_comb begin
    rx_state_nx = rx_state;
    case (rx_state)
      RX_IDLE:  if (!rx_sync) rx_state_nx = RX_START;
      RX_START: if (half_tick) rx_state_nx = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_tick && bit_idx == 3'd7) rx_state_nx = RX_STOP;
      RX_STOP:  if (bit_tick) rx_state_nx = RX_IDLE;
      default:  rx_state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      rx_sh      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_state   <= rx_state_nx;
      clk_cnt    <= (rx_state == RX_IDLE || rx_state_nx != rx_state || bit_tick) ? '0 : clk_cnt + 1'b1;
      byte_valid <= (rx_state == RX_STOP) && bit_tick && rx_sync;
      frame_err  <= (rx_state == RX_STOP) && bit_tick && !rx_sync;
      if (rx_state == RX_IDLE) bit_idx <= '0;
      if (rx_state == RX_DATA && bit_tick) begin
        rx_sh   <= {rx_sync, rx_sh[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  ld_state_t   ld_state, ld_state_nx;
  logic [1:0]  byte_cnt;
  logic [31:0] asm_sh, asm_word;
  logic [13:0] word_idx, last_idx;
  logic        last_byte;

  // rx_sh holds the received byte for as long as byte_valid is high.
  assign asm_word  = {rx_sh, asm_sh[31:8]};
  assign last_byte = byte_valid && (byte_cnt == 2'd3);

  always_comb begin
    ld_state_nx = ld_state;
    case (ld_state)
      LD_LEN: if (last_byte) begin
        if (asm_word == 32'd0) ld_state_nx = LD_DONE;
        else if (asm_word <= MAX_WORDS) ld_state_nx = LD_DATA;
      end
      LD_DATA: if (last_byte && word_idx == last_idx) ld_state_nx = LD_DONE;
      default: ld_state_nx = ld_state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_state   <= LD_LEN;
      byte_cnt   <= '0;
      asm_sh     <= '0;
      word_idx   <= '0;
      last_idx   <= '0;
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= '0;
      upg_done_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      ld_state  <= ld_state_nx;
      upg_wen_o <= 1'b0;
      if (frame_err) err_o <= 1'b0 | 1'b1;
      if (byte_valid && ld_state != LD_DONE) begin
        asm_sh   <= asm_word;
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (last_byte) begin
        case (ld_state)
          LD_LEN: begin
            // An oversize header leaves byte_cnt wrapped to 0, ready for a fresh header.
            if (asm_word > MAX_WORDS) err_o <= 1'b1;
            else if (asm_word == 32'd0) upg_done_o <= 1'b1;
            else last_idx <= asm_word[13:0] - 14'd1;
          end
          LD_DATA: begin
            upg_wen_o <= 1'b1;
            upg_dat_o <= asm_word;
            upg_adr_o <= word_idx;
            if (word_idx == last_idx) upg_done_o <= 1'b1;
            else word_idx <= word_idx + 14'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - directed self-checking bench for uart_prog_loader
module tb_uart_prog_loader;
  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        upg_wen_o;
  logic [13:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o;
  logic        err_o;

  int n_cmp = 0;
  int n_bad = 0;
  int n_str = 0;
  int base;
  logic [13:0] s_adr [0:31];
  logic [31:0] s_dat [0:31];
  logic        s_done[0:31];

  uart_prog_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx_i(rx),
    .upg_wen_o(upg_wen_o), .upg_adr_o(upg_adr_o), .upg_dat_o(upg_dat_o),
    .upg_done_o(upg_done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (upg_wen_o) begin
      if (n_str < 32) begin
        s_adr[n_str]  = upg_adr_o;
        s_dat[n_str]  = upg_dat_o;
        s_done[n_str] = upg_done_o;
      end
      n_str = n_str + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit good);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    if (good) begin
      rx = 1'b1;
      repeat (CPB) @(posedge clk);
    end else begin
      rx = 1'b0;
      repeat (CPB * 3 / 4) @(posedge clk);
      rx = 1'b1;
      repeat (CPB / 4) @(posedge clk);
    end
    repeat (CPB / 2) @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic do_reset();
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (upg_wen_o !== 1'b0)  begin n_bad++; $display("FAIL reset_wen got %0b want 0", upg_wen_o); end
    n_cmp++; if (upg_adr_o !== 14'd0) begin n_bad++; $display("FAIL reset_adr got %0h want 0", upg_adr_o); end
    n_cmp++; if (upg_dat_o !== 32'd0) begin n_bad++; $display("FAIL reset_dat got %0h want 0", upg_dat_o); end
    n_cmp++; if (upg_done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b want 0", upg_done_o); end
    n_cmp++; if (err_o !== 1'b0)      begin n_bad++; $display("FAIL reset_err got %0b want 0", err_o); end
    rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (upg_done_o !== 1'b0 || err_o !== 1'b0 || n_str !== 0)
      begin n_bad++; $display("FAIL post_release_quiet got done=%0b err=%0b strobes=%0d want 0/0/0", upg_done_o, err_o, n_str); end
  endtask

  task automatic test_single_word();
    do_reset();
    base = n_str;
    send_word(32'd1);
    send_word(32'h0000_0513);
    settle();
    n_cmp++; if (n_str - base !== 1) begin n_bad++; $display("FAIL single_count got %0d want 1", n_str - base); end
    n_cmp++; if (s_adr[base] !== 14'd0) begin n_bad++; $display("FAIL single_adr got %0h want 0", s_adr[base]); end
    n_cmp++; if (s_dat[base] !== 32'h0000_0513) begin n_bad++; $display("FAIL single_dat got %0h want 513", s_dat[base]); end
    n_cmp++; if (s_done[base] !== 1'b1) begin n_bad++; $display("FAIL single_done_with_strobe got %0b want 1", s_done[base]); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL single_err got %0b want 0", err_o); end
    send_byte(8'hFF, 1'b1);
    settle();
    n_cmp++; if (n_str - base !== 1 || upg_done_o !== 1'b1)
      begin n_bad++; $display("FAIL done_ignores_bytes got strobes=%0d done=%0b want 1/1", n_str - base, upg_done_o); end
  endtask

  task automatic test_three_words();
    logic [31:0] words [0:2];
    words[0] = 32'h1111_1111;
    words[1] = 32'h2222_2222;
    words[2] = 32'h3333_3333;
    do_reset();
    base = n_str;
    send_word(32'd3);
    for (int i = 0; i < 3; i++) send_word(words[i]);
    settle();
    n_cmp++; if (n_str - base !== 3) begin n_bad++; $display("FAIL three_count got %0d want 3", n_str - base); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (s_adr[base+i] !== 14'(i)) begin n_bad++; $display("FAIL three_adr[%0d] got %0h want %0h", i, s_adr[base+i], i); end
      n_cmp++; if (s_dat[base+i] !== words[i]) begin n_bad++; $display("FAIL three_dat[%0d] got %0h want %0h", i, s_dat[base+i], words[i]); end
      n_cmp++; if (s_done[base+i] !== (i == 2)) begin n_bad++; $display("FAIL three_done[%0d] got %0b want %0b", i, s_done[base+i], i == 2); end
    end
  endtask

  task automatic test_frame_error();
    do_reset();
    base = n_str;
    send_word(32'd1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b0);
    settle();
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL frame_err_flag got %0b want 1", err_o); end
    n_cmp++; if (n_str - base !== 0) begin n_bad++; $display("FAIL frame_err_no_strobe got %0d want 0", n_str - base); end
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    settle();
    n_cmp++; if (n_str - base !== 1) begin n_bad++; $display("FAIL frame_resend_count got %0d want 1", n_str - base); end
    n_cmp++; if (s_dat[base] !== 32'h1234_5678) begin n_bad++; $display("FAIL frame_resend_dat got %0h want 12345678", s_dat[base]); end
    n_cmp++; if (upg_done_o !== 1'b1 || err_o !== 1'b1)
      begin n_bad++; $display("FAIL frame_resend_flags got done=%0b err=%0b want 1/1", upg_done_o, err_o); end
  endtask

  task automatic test_oversize_header();
    do_reset();
    base = n_str;
    send_word(32'h0000_4001);
    settle();
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL oversize_err got %0b want 1", err_o); end
    n_cmp++; if (n_str - base !== 0 || upg_done_o !== 1'b0)
      begin n_bad++; $display("FAIL oversize_quiet got strobes=%0d done=%0b want 0/0", n_str - base, upg_done_o); end
    send_word(32'd0);
    settle();
    n_cmp++; if (upg_done_o !== 1'b1) begin n_bad++; $display("FAIL zero_header_done got %0b want 1", upg_done_o); end
    n_cmp++; if (n_str - base !== 0) begin n_bad++; $display("FAIL zero_header_no_strobe got %0d want 0", n_str - base); end
  endtask

  task automatic test_reset_mid_image();
    do_reset();
    base = n_str;
    send_word(32'd2);
    send_word(32'hAABB_CCDD);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    settle();
    n_cmp++; if (n_str - base !== 1) begin n_bad++; $display("FAIL midrst_pre_count got %0d want 1", n_str - base); end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, err_o} !== 49'd0)
      begin n_bad++; $display("FAIL midrst_outputs got wen=%0b adr=%0h dat=%0h done=%0b err=%0b want all 0", upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, err_o); end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    base = n_str;
    send_word(32'd2);
    send_word(32'h0102_0304);
    send_word(32'hCAFE_F00D);
    settle();
    n_cmp++; if (n_str - base !== 2) begin n_bad++; $display("FAIL midrst_count got %0d want 2", n_str - base); end
    n_cmp++; if (s_adr[base] !== 14'd0 || s_dat[base] !== 32'h0102_0304 || s_done[base] !== 1'b0)
      begin n_bad++; $display("FAIL midrst_word0 got adr=%0h dat=%0h done=%0b want 0/01020304/0", s_adr[base], s_dat[base], s_done[base]); end
    n_cmp++; if (s_adr[base+1] !== 14'd1 || s_dat[base+1] !== 32'hCAFE_F00D || s_done[base+1] !== 1'b1)
      begin n_bad++; $display("FAIL midrst_word1 got adr=%0h dat=%0h done=%0b want 1/cafef00d/1", s_adr[base+1], s_dat[base+1], s_done[base+1]); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL midrst_err got %0b want 0", err_o); end
  endtask

  task automatic test_glitch();
    do_reset();
    base = n_str;
    rx = 1'b0;
    repeat (CPB * 3 / 10) @(posedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (err_o !== 1'b0 || n_str - base !== 0)
      begin n_bad++; $display("FAIL glitch_quiet got err=%0b strobes=%0d want 0/0", err_o, n_str - base); end
    send_word(32'd1);
    send_word(32'hDEAD_BEEF);
    settle();
    n_cmp++; if (n_str - base !== 1) begin n_bad++; $display("FAIL glitch_after_count got %0d want 1", n_str - base); end
    n_cmp++; if (s_dat[base] !== 32'hDEAD_BEEF || s_adr[base] !== 14'd0)
      begin n_bad++; $display("FAIL glitch_after_word got adr=%0h dat=%0h want 0/deadbeef", s_adr[base], s_dat[base]); end
    n_cmp++; if (err_o !== 1'b0 || upg_done_o !== 1'b1)
      begin n_bad++; $display("FAIL glitch_after_flags got err=%0b done=%0b want 0/1", err_o, upg_done_o); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_three_words();
    test_frame_error();
    test_oversize_header();
    test_reset_mid_image();
    test_glitch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
